mem_access_unit: RTL and testbench

//  MEM-stage load/store initiator for the pipelined MIPS core. Accepts one load/store request,

---
 rtl/mips_mem_pkg.sv | 52 +++++
 rtl/mem_lane_mux.sv | 48 ++++
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage load/store initiator.
// Contents:
//   mem_op_e  - request opcode encoding (LW..SB)
//   state_e   - access FSM state encoding
//   byte_lsb  - LSB position of the addressed byte in a big-endian word
//   half_lsb  - LSB position of the addressed halfword in a big-endian word
//   is_load   - true for the five load opcodes
//   misaligned- alignment rule per opcode
package mips_mem_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_SETUP  = 3'd1,
    ST_RD_STROBE = 3'd2,
    ST_WR_SETUP  = 3'd3,
    ST_WR_STROBE = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

  // Big-endian: byte offset 0 lives in bits [31:24], so offset o starts at 24-8o.
  function automatic logic [4:0] byte_lsb(input logic [1:0] off);
    return 5'(5'd24 - {off, 3'b000});
  endfunction

  function automatic logic [4:0] half_lsb(input logic [1:0] off);
    return off[1] ? 5'd0 : 5'd16;
  endfunction

  function automatic logic is_load(input mem_op_e op);
    return !(op inside {OP_SW, OP_SH, OP_SB});
  endfunction

  function automatic logic misaligned(input mem_op_e op, input logic [1:0] off);
    case (op)
      OP_LW, OP_SW:         return off != 2'b00;
      OP_LH, OP_LHU, OP_SH: return off[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_mux.sv
// Combinational lane steering for the load/store unit.
// Ports:
//   op         in  request opcode
//   offset     in  byte offset within the word (addr[1:0])
//   word       in  word read from memory
//   wdata      in  store data (SH uses [15:0], SB uses [7:0])
//   load_data  out loaded value, sign- or zero-extended per opcode
//   merge_word out word with only the addressed lane(s) replaced by store data
module mem_lane_mux
  import mips_mem_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic [4:0]         b_lsb;
  logic [4:0]         h_lsb;
  logic signed [7:0]  byte_v;
  logic signed [15:0] half_v;

  always_comb begin
    b_lsb  = byte_lsb(offset);
    h_lsb  = half_lsb(offset);
    byte_v = word[b_lsb +: 8];
    half_v = word[h_lsb +: 16];

    case (op)
      OP_LH:   load_data = 32'(half_v);
      OP_LHU:  load_data = {16'h0000, half_v};
      OP_LB:   load_data = 32'(byte_v);
      OP_LBU:  load_data = {24'h000000, byte_v};
      default: load_data = word;
    endcase

    merge_word = word;
    case (op)
      OP_SW:   merge_word = wdata;
      OP_SH:   merge_word[h_lsb +: 16] = wdata[15:0];
      OP_SB:   merge_word[b_lsb +: 8]  = wdata[7:0];
      default: merge_word = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for the pipelined MIPS core.
// Accepts one request at a time, drives the data-memory strobe interface and
// returns extended load data. Sub-word stores read-modify-write the aligned word.
// Ports:
//   clk, reset              clock; synchronous active-low reset
//   req_valid/req_ready     request handshake (req_ready low = MEM-stage stall)
//   req_op/addr/wdata       request opcode, byte address, store data
//   resp_valid/rdata/err    one-cycle completion pulse with data and error flag
//   data_address/write_data word-aligned memory address and write word
//   MemRead/MemWrite        one-cycle registered strobes (memory acts on rising edge)
//   read_data               word returned by memory (big-endian lanes)
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int MEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] data_address,
  output logic [31:0] write_data,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] read_data
);

  state_e      state, state_nxt;
  mem_op_e     req_op_e;
  mem_op_e     op_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        req_err;
  logic [31:0] req_word_addr;
  logic [31:0] lane_load;
  logic [31:0] lane_merge;

  logic        req_ready_nxt;
  logic        resp_valid_nxt;
  logic [31:0] resp_rdata_nxt;
  logic        resp_err_nxt;
  logic [31:0] data_address_nxt;
  logic [31:0] write_data_nxt;
  logic        mem_read_nxt;
  logic        mem_write_nxt;

  assign req_op_e      = mem_op_e'(req_op);
  assign req_word_addr = {req_addr[31:2], 2'b00};
  // Full 32-bit compare so high address bits flag an error instead of wrapping.
  assign req_err       = misaligned(req_op_e, req_addr[1:0]) ||
                         (req_word_addr > 32'(MEM_BYTES - 4));
  assign accept        = req_valid && req_ready;

  mem_lane_mux u_lane_mux (
    .op         (op_q),
    .offset     (off_q),
    .word       (read_data),
    .wdata      (wdata_q),
    .load_data  (lane_load),
    .merge_word (lane_merge)
  );

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt        = state;
    data_address_nxt = data_address;
    write_data_nxt   = write_data;
    mem_read_nxt     = 1'b0;
    mem_write_nxt    = 1'b0;
    resp_valid_nxt   = 1'b0;
    resp_rdata_nxt   = resp_rdata;
    resp_err_nxt     = resp_err;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          resp_rdata_nxt = '0;
          resp_err_nxt   = 1'b0;
          if (req_err) begin
            state_nxt      = ST_RESP;
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
          end else if (req_op_e == OP_SW) begin
            state_nxt        = ST_WR_SETUP;
            data_address_nxt = req_word_addr;
            write_data_nxt   = req_wdata;
          end else begin
            // Loads and sub-word stores both start with a read of the word.
            state_nxt        = ST_RD_SETUP;
            data_address_nxt = req_word_addr;
          end
        end
      end
      ST_RD_SETUP: begin
        state_nxt    = ST_RD_STROBE;
        mem_read_nxt = 1'b1;
      end
      ST_RD_STROBE: begin
        if (is_load(op_q)) begin
          state_nxt      = ST_RESP;
          resp_valid_nxt = 1'b1;
          resp_rdata_nxt = lane_load;
        end else begin
          state_nxt      = ST_WR_SETUP;
          write_data_nxt = lane_merge;
        end
      end
      ST_WR_SETUP: begin
        state_nxt     = ST_WR_STROBE;
        mem_write_nxt = 1'b1;
      end
      ST_WR_STROBE: begin
        state_nxt      = ST_RESP;
        resp_valid_nxt = 1'b1;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    req_ready_nxt = (state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      data_address <= '0;
      write_data   <= '0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
    end else begin
      req_ready    <= req_ready_nxt;
      resp_valid   <= resp_valid_nxt;
      resp_rdata   <= resp_rdata_nxt;
      resp_err     <= resp_err_nxt;
      data_address <= data_address_nxt;
      write_data   <= write_data_nxt;
      MemRead      <= mem_read_nxt;
      MemWrite     <= mem_write_nxt;
    end
  end

  // Request capture; only meaningful while a request is in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= req_op_e;
      off_q   <= req_addr[1:0];
      wdata_q <= req_wdata;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] data_address;
  logic [31:0] write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] read_data = '0;

  logic [31:0] mem [0:7];
  int vectors = 0;
  int miscompares = 0;
  int rd_edges = 0;
  int wr_edges = 0;
  int cyc = 0;
  int viol = 0;
  int rise_q[$];
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;

  mem_access_unit #(.MEM_BYTES(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .data_address (data_address),
    .write_data   (write_data),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .read_data    (read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Memory model: acts on strobe rising edges, big-endian word storage.
  always @(posedge MemRead) begin
    rd_edges++;
    rise_q.push_back(cyc);
    read_data = mem[data_address[4:2]];
  end

  always @(posedge MemWrite) begin
    wr_edges++;
    mem[data_address[4:2]] = write_data;
  end

  // Strobe rules: never both high, each high for a single cycle.
  always @(negedge clk) begin
    if (MemRead && MemWrite) viol++;
    if (MemRead && prev_rd) viol++;
    if (MemWrite && prev_wr) viol++;
    prev_rd = MemRead;
    prev_wr = MemWrite;
  end

  task automatic preload();
    for (int i = 0; i < 8; i++)
      mem[i] = {8'(20 + 4*i), 8'(21 + 4*i), 8'(22 + 4*i), 8'(23 + 4*i)};
  endtask

  // Issues one request from a negedge and returns at the negedge after the response.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int nrd, output int nwr);
    int r0, w0, guard;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    r0 = rd_edges; w0 = wr_edges;
    req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!resp_valid) lat = -1;
    rd = resp_rdata; er = resp_err;
    @(negedge clk);
    nrd = rd_edges - r0; nwr = wr_edges - w0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if ({MemRead, MemWrite, resp_valid, resp_err, data_address, write_data, resp_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs rd=%b wr=%b rv=%b er=%b addr=%h wd=%h rdata=%h want all zero",
               MemRead, MemWrite, resp_valid, resp_err, data_address, write_data, resp_rdata);
    end
    vectors++;
    reset = 1'b1;
    @(negedge clk);
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready got %b want 1", req_ready);
    end
    vectors++;
  endtask

  task automatic test_lw();
    logic [31:0] rd; logic er; int lat, nrd, nwr;
    do_req(LW, 32'd4, 32'd0, rd, er, lat, nrd, nwr);
    if (rd !== 32'h18191A1B) begin miscompares++; $display("FAIL lw4_data got %h want 18191a1b", rd); end
    vectors++;
    if (er !== 1'b0) begin miscompares++; $display("FAIL lw4_err got %b want 0", er); end
    vectors++;
    if (lat !== 2 || nrd !== 1 || nwr !== 0) begin
      miscompares++; $display("FAIL lw4_timing lat=%0d rd=%0d wr=%0d want 2/1/0", lat, nrd, nwr);
    end
    vectors++;
  endtask

  task automatic test_sb();
    logic [31:0] rd; logic er; int lat, nrd, nwr;
    do_req(SB, 32'd9, 32'h00000080, rd, er, lat, nrd, nwr);
    if (rd !== 32'h0 || er !== 1'b0) begin
      miscompares++; $display("FAIL sb9_resp rdata=%h err=%b want 0/0", rd, er);
    end
    vectors++;
    if (lat !== 4 || nrd !== 1 || nwr !== 1) begin
      miscompares++; $display("FAIL sb9_timing lat=%0d rd=%0d wr=%0d want 4/1/1", lat, nrd, nwr);
    end
    vectors++;
    if (data_address !== 32'd8) begin
      miscompares++; $display("FAIL sb9_address got %h want 00000008", data_address);
    end
    vectors++;
    do_req(LB, 32'd9, 32'd0, rd, er, lat, nrd, nwr);
    if (rd !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb9 got %h want ffffff80", rd); end
    vectors++;
    do_req(LBU, 32'd9, 32'd0, rd, er, lat, nrd, nwr);
    if (rd !== 32'h00000080) begin miscompares++; $display("FAIL lbu9 got %h want 00000080", rd); end
    vectors++;
    do_req(LW, 32'd8, 32'd0, rd, er, lat, nrd, nwr);
    if (rd !== 32'h1C801E1F) begin miscompares++; $display("FAIL lw8 got %h want 1c801e1f", rd); end
    vectors++;
  endtask

  task automatic test_sh();
    logic [31:0] rd; logic er; int lat, nrd, nwr;
    do_req(SH, 32'd2, 32'h1234BEEF, rd, er, lat, nrd, nwr);
    if (lat !== 4 || nrd !== 1 || nwr !== 1 || er !== 1'b0) begin
      miscompares++; $display("FAIL sh2_timing lat=%0d rd=%0d wr=%0d err=%b want 4/1/1/0", lat, nrd, nwr, er);
    end
    vectors++;
    do_req(LW, 32'd0, 32'd0, rd, er, lat, nrd, nwr);
    if (rd !== 32'h1415BEEF) begin miscompares++; $display("FAIL lw0 got %h want 1415beef", rd); end
    vectors++;
    do_req(LHU, 32'd2, 32'd0, rd, er, lat, nrd, nwr);
    if (rd !== 32'h0000BEEF) begin miscompares++; $display("FAIL lhu2 got %h want 0000beef", rd); end
    vectors++;
    do_req(LH, 32'd2, 32'd0, rd, er, lat, nrd, nwr);
    if (rd !== 32'hFFFFBEEF) begin miscompares++; $display("FAIL lh2 got %h want ffffbeef", rd); end
    vectors++;
    do_req(LH, 32'd0, 32'd0, rd, er, lat, nrd, nwr);
    if (rd !== 32'h00001415) begin miscompares++; $display("FAIL lh0 got %h want 00001415", rd); end
    vectors++;
  endtask

  task automatic test_errors();
    logic [2:0]  ops [4]   = '{LW, SH, LW, LW};
    logic [31:0] addrs [4] = '{32'd6, 32'd3, 32'd32, 32'h80000004};
    logic [31:0] rd; logic er; int lat, nrd, nwr;
    for (int i = 0; i < 4; i++) begin
      do_req(ops[i], addrs[i], 32'hFFFFFFFF, rd, er, lat, nrd, nwr);
      if (er !== 1'b1 || rd !== 32'h0) begin
        miscompares++; $display("FAIL err%0d_resp err=%b rdata=%h want 1/0", i, er, rd);
      end
      vectors++;
      if (lat !== 0 || nrd !== 0 || nwr !== 0) begin
        miscompares++; $display("FAIL err%0d_timing lat=%0d rd=%0d wr=%0d want 0/0/0", i, lat, nrd, nwr);
      end
      vectors++;
    end
  endtask

  task automatic test_sw_boundary();
    logic [31:0] rd; logic er; int lat, nrd, nwr;
    do_req(SW, 32'd12, 32'hDEADBEEF, rd, er, lat, nrd, nwr);
    if (lat !== 2 || nrd !== 0 || nwr !== 1 || er !== 1'b0 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL sw12 lat=%0d rd=%0d wr=%0d err=%b rdata=%h want 2/0/1/0/0", lat, nrd, nwr, er, rd);
    end
    vectors++;
    do_req(LW, 32'd12, 32'd0, rd, er, lat, nrd, nwr);
    if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw12 got %h want deadbeef", rd); end
    vectors++;
    do_req(LB, 32'd12, 32'd0, rd, er, lat, nrd, nwr);
    if (rd !== 32'hFFFFFFDE) begin miscompares++; $display("FAIL lb12 got %h want ffffffde", rd); end
    vectors++;
    do_req(LW, 32'd28, 32'd0, rd, er, lat, nrd, nwr);
    if (rd !== 32'h30313233 || er !== 1'b0) begin
      miscompares++; $display("FAIL lw28 got %h err=%b want 30313233/0", rd, er);
    end
    vectors++;
    do_req(LBU, 32'd31, 32'd0, rd, er, lat, nrd, nwr);
    if (rd !== 32'h00000033) begin miscompares++; $display("FAIL lbu31 got %h want 00000033", rd); end
    vectors++;
    do_req(LHU, 32'd30, 32'd0, rd, er, lat, nrd, nwr);
    if (rd !== 32'h00003233) begin miscompares++; $display("FAIL lhu30 got %h want 00003233", rd); end
    vectors++;
  endtask

  task automatic test_back_to_back();
    int resp_cnt, ready_hi, bad_data;
    resp_cnt = 0; ready_hi = 0; bad_data = 0;
    rise_q.delete();
    req_op = LW; req_addr = 32'd4; req_wdata = '0; req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        resp_cnt++;
        if (resp_rdata !== 32'h18191A1B) bad_data++;
      end
      if (req_ready) ready_hi++;
    end
    req_valid = 1'b0;
    @(negedge clk);
    if (resp_cnt !== 3 || bad_data !== 0) begin
      miscompares++; $display("FAIL b2b_resp count=%0d bad=%0d want 3/0", resp_cnt, bad_data);
    end
    vectors++;
    if (ready_hi !== 3) begin
      miscompares++; $display("FAIL b2b_ready high_cycles=%0d want 3", ready_hi);
    end
    vectors++;
    if (rise_q.size() !== 3) begin
      miscompares++; $display("FAIL b2b_strobes count=%0d want 3", rise_q.size());
    end else if (rise_q[1] - rise_q[0] !== 4 || rise_q[2] - rise_q[1] !== 4) begin
      miscompares++;
      $display("FAIL b2b_gap spacing=%0d,%0d want 4,4", rise_q[1] - rise_q[0], rise_q[2] - rise_q[1]);
    end
    vectors++;
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd; logic er; int lat, nrd, nwr, r0, w0;
    preload();
    r0 = rd_edges; w0 = wr_edges;
    req_op = SB; req_addr = 32'd0; req_wdata = 32'h000000AB; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    if (MemWrite !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_state wr=%b ready=%b rv=%b want 0/1/0", MemWrite, req_ready, resp_valid);
    end
    vectors++;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    if (wr_edges - w0 !== 0 || rd_edges - r0 !== 1) begin
      miscompares++;
      $display("FAIL midreset_strobes wr=%0d rd=%0d want 0/1", wr_edges - w0, rd_edges - r0);
    end
    vectors++;
    do_req(LW, 32'd0, 32'd0, rd, er, lat, nrd, nwr);
    if (rd !== 32'h14151617) begin miscompares++; $display("FAIL midreset_lw0 got %h want 14151617", rd); end
    vectors++;
  endtask

  task automatic test_protocol();
    if (viol !== 0) begin
      miscompares++; $display("FAIL strobe_rules violations=%0d want 0", viol);
    end
    vectors++;
  endtask

  initial begin
    preload();
    test_reset();
    test_lw();
    test_sb();
    test_sh();
    test_errors();
    test_sw_boundary();
    test_back_to_back();
    test_reset_midop();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
